// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// F-stage PC register and F/D pipeline register of the P7 MIPS pipeline.
// The PC register takes the next PC from the NPC block. The current PC goes
// back to NPC and to instruction memory. Each fetched word is checked for an
// address error (AdEL) and passed to D together with its ExcCode and its
// branch-delay tag. This block also handles hazard stalls, the redirect on
// exception entry, and the squash of the slot that follows an eret.
//
// Ports
//   clk           in   1   system clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   npc           in  32   next PC from the NPC block
//   i_inst_rdata  in  32   IM read data at F_PC (combinational)
//   stall         in   1   hazard stall: hold PC and F/D
//   req           in   1   exception/interrupt accepted: go to handler
//   D_is_jump     in   1   D holds a branch/jump, so F is its delay slot
//   D_eret        in   1   D holds eret
//   F_PC          out 32   current fetch PC
//   D_PC          out 32   PC of the instruction in D
//   D_instr       out 32   instruction in D
//   D_ExcCode     out  5   fetch exception code carried into D (0 = none)
//   D_BD          out  1   instruction in D is a branch delay slot
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic [31:0] i_inst_rdata,
    input  logic        stall,
    input  logic        req,
    input  logic        D_is_jump,
    input  logic        D_eret,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD
);

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_NONE = 5'd0;

    logic [31:0] f_pc_q,      f_pc_d;
    logic [31:0] d_pc_q,      d_pc_d;
    logic [31:0] d_instr_q,   d_instr_d;
    logic [4:0]  d_exc_q,     d_exc_d;
    logic        d_bd_q,      d_bd_d;

    logic        f_exc;
    logic [4:0]  f_exc_code;
    logic [31:0] f_instr;

    // The address check runs on the registered PC. npc therefore has no
    // combinational path to any output. A misaligned or out-of-range fetch
    // becomes a nop, so the bad word never reaches decode.
    always_comb begin
        f_exc      = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_LO) || (f_pc_q > IM_HI);
        f_exc_code = f_exc ? EXC_ADEL : EXC_NONE;
        f_instr    = f_exc ? 32'h0 : i_inst_rdata;
    end

    // Next state, in priority order: req, then stall, then eret squash,
    // then normal advance.
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        f_pc_d    = f_pc_q;
        d_pc_d    = d_pc_q;
        d_instr_d = d_instr_q;
        d_exc_d   = d_exc_q;
        d_bd_d    = d_bd_q;

        if (req) begin
            // The flushed bubble carries the handler PC, so the visible
            // PC in D stays meaningful.
            f_pc_d    = HANDLER_PC;
            d_pc_d    = HANDLER_PC;
            d_instr_d = 32'h0;
            d_exc_d   = EXC_NONE;
            d_bd_d    = 1'b0;
        end else if (stall) begin
            // Hold everything. A pending eret squash waits until the stall clears.
        end else if (D_eret) begin
            f_pc_d    = npc;
            d_pc_d    = f_pc_q;
            d_instr_d = 32'h0;
            d_exc_d   = EXC_NONE;
            d_bd_d    = 1'b0;
        end else begin
            f_pc_d    = npc;
            d_pc_d    = f_pc_q;
            d_instr_d = f_instr;
            d_exc_d   = f_exc_code;
            d_bd_d    = D_is_jump;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Reset is
    // asynchronous, so outputs return to their reset values without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q    <= RESET_PC;
            d_pc_q    <= RESET_PC;
            d_instr_q <= 32'h0;
            d_exc_q   <= EXC_NONE;
            d_bd_q    <= 1'b0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_pc_q    <= d_pc_d;
            d_instr_q <= d_instr_d;
            d_exc_q   <= d_exc_d;
            d_bd_q    <= d_bd_d;
        end
    end

    assign F_PC      = f_pc_q;
    assign D_PC      = d_pc_q;
    assign D_instr   = d_instr_q;
    assign D_ExcCode = d_exc_q;
    assign D_BD      = d_bd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. All expected values are worked out by
// hand from the stimulus. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic [31:0] i_inst_rdata;
    logic        stall;
    logic        req;
    logic        D_is_jump;
    logic        D_eret;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .npc          (npc),
        .i_inst_rdata (i_inst_rdata),
        .stall        (stall),
        .req          (req),
        .D_is_jump    (D_is_jump),
        .D_eret       (D_eret),
        .F_PC         (F_PC),
        .D_PC         (D_PC),
        .D_instr      (D_instr),
        .D_ExcCode    (D_ExcCode),
        .D_BD         (D_BD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one rising edge, then settle 1 unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [4:0] exc, input logic bd);
        check({tag, ".D_PC"},      D_PC,             pc);
        check({tag, ".D_instr"},   D_instr,          instr);
        check({tag, ".D_ExcCode"}, {27'h0, D_ExcCode}, {27'h0, exc});
        check({tag, ".D_BD"},      {31'h0, D_BD},    {31'h0, bd});
    endtask

    initial begin
        reset        = 1'b1;
        npc          = 32'h0000_3000;
        i_inst_rdata = 32'h1111_1111;
        stall        = 1'b0;
        req          = 1'b0;
        D_is_jump    = 1'b0;
        D_eret       = 1'b0;

        // Reset state
        #2;
        check("rst.F_PC", F_PC, 32'h3000);
        check_d("rst", 32'h3000, 32'h0, 5'd0, 1'b0);
        reset = 1'b0;

        // Normal advance: F_PC=3000 holds a legal word
        npc = 32'h3004;
        step();
        check("run1.F_PC", F_PC, 32'h3004);
        check_d("run1", 32'h3000, 32'h1111_1111, 5'd0, 1'b0);
        npc = 32'h3010;
        step();
        check("run2.F_PC", F_PC, 32'h3010);

        // Reset mid-run takes effect without a clock edge
        reset = 1'b1;
        #1;
        check("midrst.F_PC", F_PC, 32'h3000);
        check_d("midrst", 32'h3000, 32'h0, 5'd0, 1'b0);
        reset = 1'b0;
        npc   = 32'h3004;
        step();
        check("postrst.F_PC", F_PC, 32'h3004);
        check("postrst.D_PC", D_PC, 32'h3000);
        check("postrst.D_instr", D_instr, 32'h1111_1111);

        // Stall for three cycles: everything holds
        npc          = 32'h3008;
        i_inst_rdata = 32'h2408_0001;
        stall        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.F_PC", F_PC, 32'h3004);
            check_d("stall", 32'h3000, 32'h1111_1111, 5'd0, 1'b0);
        end
        stall = 1'b0;
        step();
        check("unstall.F_PC", F_PC, 32'h3008);
        check_d("unstall", 32'h3004, 32'h2408_0001, 5'd0, 1'b0);

        // Misaligned fetch: AdEL
        npc = 32'h3002;
        step();
        check("mis.F_PC", F_PC, 32'h3002);
        npc = 32'h3010;
        step();
        check_d("mis", 32'h3002, 32'h0, 5'd4, 1'b0);

        // Above IM_HI: AdEL
        npc = 32'h7000;
        step();
        check("hi.F_PC", F_PC, 32'h7000);
        check_d("ok3010", 32'h3010, 32'h2408_0001, 5'd0, 1'b0);
        npc = 32'h3010;
        step();
        check_d("hi", 32'h7000, 32'h0, 5'd4, 1'b0);

        // Delay slot tagging; 6FFC is the highest legal address
        D_is_jump    = 1'b1;
        i_inst_rdata = 32'h1234_5678;
        npc          = 32'h6FFC;
        step();
        check("bd.F_PC", F_PC, 32'h6FFC);
        check_d("bd1", 32'h3010, 32'h1234_5678, 5'd0, 1'b1);
        D_is_jump = 1'b0;
        npc       = 32'h0;
        step();
        check_d("bd0_imhi", 32'h6FFC, 32'h1234_5678, 5'd0, 1'b0);
        check("wrap.F_PC", F_PC, 32'h0);
        npc = 32'h3000;
        step();
        check_d("wrap", 32'h0, 32'h0, 5'd4, 1'b0);

        // req overrides stall (and D_is_jump)
        req       = 1'b1;
        stall     = 1'b1;
        D_is_jump = 1'b1;
        npc       = 32'h3020;
        step();
        check("req.F_PC", F_PC, 32'h4180);
        check_d("req", 32'h4180, 32'h0, 5'd0, 1'b0);
        req       = 1'b0;
        stall     = 1'b0;
        D_is_jump = 1'b0;
        step();
        check("hdl.F_PC", F_PC, 32'h3020);
        check_d("hdl", 32'h4180, 32'h1234_5678, 5'd0, 1'b0);

        // eret with stall: hold and defer the squash
        D_eret = 1'b1;
        stall  = 1'b1;
        npc    = 32'h3050;
        step();
        check("eretstall.F_PC", F_PC, 32'h3020);
        check_d("eretstall", 32'h4180, 32'h1234_5678, 5'd0, 1'b0);
        // eret without stall: squash the slot
        stall = 1'b0;
        step();
        check("eret.F_PC", F_PC, 32'h3050);
        check_d("eret", 32'h3020, 32'h0, 5'd0, 1'b0);
        D_eret = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
